// File: rtl/data_memory_lsu.sv
// Data memory and load/store unit: byte/half/word stores with byte enables,
// sign/zero-extended combinational loads, post-reset clear sweep, sticky misalignment fault.
module data_memory_lsu #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        MisalignFault,
  output logic [31:0] FaultAddr
);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  size_t             size;
  logic              is_unsigned;
  logic              load_legal;
  logic              store_legal;
  logic              aligned;
  logic              do_load;
  logic              do_store;
  logic              fault_evt;
  logic [3:0]        byte_en;
  logic [31:0]       lane_data;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    Busy       = reset;
    case (state)
      S_CLEAR: begin
        Busy = 1'b1;
        if (clr_cnt == LAST_IDX) state_next = S_IDLE;
      end
      S_IDLE:  state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  always_comb begin
    word_idx    = Addr[ADDR_W+1:2];
    size        = size_t'(funct3[1:0]);
    is_unsigned = funct3[2];
    load_legal  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
    store_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

    case (size)
      SZ_HALF: aligned = ~Addr[0];
      SZ_WORD: aligned = (Addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    do_load   = ~Busy & MemRead & load_legal & aligned;
    do_store  = ~Busy & MemWrite & store_legal & aligned;
    // Illegal-funct3 accesses are dropped without ever being classed as misaligned.
    fault_evt = ~Busy & ~aligned & ((MemRead & load_legal) | (MemWrite & store_legal));
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = WriteData;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << Addr[1:0];
        lane_data = {4{WriteData[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = Addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{WriteData[15:0]}};
      end
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; it is zeroed by the clear sweep, which
  // keeps it mappable onto RAM rather than DEPTH*32 resettable flops.
  always_ff @(posedge clk) begin
    if (!reset && state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path (combinational; returns pre-write data during a same-cycle store)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word  = mem[word_idx];
    rd_byte  = 8'(rd_word >> {Addr[1:0], 3'b000});
    rd_half  = Addr[1] ? rd_word[31:16] : rd_word[15:0];
    ReadData = '0;
    if (do_load) begin
      case (size)
        SZ_BYTE: ReadData = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        SZ_HALF: ReadData = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        SZ_WORD: ReadData = rd_word;
        default: ReadData = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky misalignment fault; FaultAddr captures only the first offender
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      MisalignFault <= 1'b0;
      FaultAddr     <= '0;
    end else if (fault_evt) begin
      MisalignFault <= 1'b1;
      if (!MisalignFault) FaultAddr <= Addr;
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: stimulus pushes expected load data,
// a negedge monitor pops and compares whenever a load is presented.
module tb_data_memory_lsu;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_X  = 3'b011;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Busy;
  logic        MisalignFault;
  logic [31:0] FaultAddr;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  int        total = 0;
  int        bad   = 0;
  int        n_busy;

  data_memory_lsu #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .funct3       (funct3),
    .Addr         (Addr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Busy         (Busy),
    .MisalignFault(MisalignFault),
    .FaultAddr    (FaultAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] exp);
    sb_entry_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: a presented load is any negedge with MemRead high.
  always @(negedge clk) begin
    if (MemRead === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load: got 0x%08h expected no load", ReadData);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, ReadData, mon_e.exp);
      end
    end
  end

  // One access per cycle, driven just after the posedge.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string name);
    @(posedge clk);
    #1;
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    Addr      = a;
    WriteData = wd;
    if (rd) push(name, exp);
  endtask

  task automatic idle_op();
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Single-cycle reset pulse; a load held during reset must read 0.
  task automatic reset_pulse(input string name);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    funct3   = F_W;
    Addr     = 32'h10;
    push({name, "_rd_in_reset"}, 32'h0);
    @(negedge clk);
    check({name, "_busy_in_reset"}, {31'h0, Busy}, 32'h1);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    MemRead = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    funct3    = F_W;
    Addr      = '0;
    WriteData = '0;

    // Power-up sweep
    reset_pulse("init");
    count_busy(n_busy);
    check("busy_len_init", n_busy, 256);
    check("fault_after_reset", {31'h0, MisalignFault}, 32'h0);
    check("faultaddr_after_reset", FaultAddr, 32'h0);
    do_op(1, 0, F_W, 32'h0,   0, 32'h0, "lw_clear_0x000");
    do_op(1, 0, F_W, 32'h80,  0, 32'h0, "lw_clear_0x080");
    do_op(1, 0, F_W, 32'h3FC, 0, 32'h0, "lw_clear_0x3fc");

    // Word store, then every load width/extension
    do_op(0, 1, F_W,  32'h10, 32'hDEADBEEF, 0, "");
    do_op(1, 0, F_W,  32'h10, 0, 32'hDEADBEEF, "lw_0x10");
    do_op(1, 0, F_B,  32'h13, 0, 32'hFFFFFFDE, "lb_0x13");
    do_op(1, 0, F_BU, 32'h13, 0, 32'h000000DE, "lbu_0x13");
    do_op(1, 0, F_B,  32'h10, 0, 32'hFFFFFFEF, "lb_0x10");
    do_op(1, 0, F_BU, 32'h11, 0, 32'h000000BE, "lbu_0x11");
    do_op(1, 0, F_H,  32'h10, 0, 32'hFFFFBEEF, "lh_0x10");
    do_op(1, 0, F_HU, 32'h12, 0, 32'h0000DEAD, "lhu_0x12");

    // Partial stores touch only their lanes
    do_op(0, 1, F_B,  32'h11, 32'h123456AA, 0, "");
    do_op(1, 0, F_W,  32'h10, 0, 32'hDEADAAEF, "lw_after_sb");
    do_op(1, 0, F_B,  32'h11, 0, 32'hFFFFFFAA, "lb_0x11");
    do_op(0, 1, F_H,  32'h12, 32'h00007777, 0, "");
    do_op(1, 0, F_W,  32'h10, 0, 32'h7777AAEF, "lw_after_sh");
    do_op(1, 0, F_H,  32'h12, 0, 32'h00007777, "lh_positive");
    do_op(1, 0, F_W,  32'hFFFFFC10, 0, 32'h7777AAEF, "lw_upper_bits_ignored");
    check("no_fault_yet", {31'h0, MisalignFault}, 32'h0);

    // Misaligned accesses
    do_op(0, 1, F_W,  32'h12, 32'h11111111, 0, "");
    do_op(1, 0, F_W,  32'h10, 0, 32'h7777AAEF, "lw_after_misalign_sw");
    check("fault_set", {31'h0, MisalignFault}, 32'h1);
    check("faultaddr_first", FaultAddr, 32'h12);
    do_op(1, 0, F_H,  32'h21, 0, 32'h0, "lh_misaligned_zero");
    idle_op();
    check("fault_sticky", {31'h0, MisalignFault}, 32'h1);
    check("faultaddr_kept", FaultAddr, 32'h12);

    // Address wrap and illegal funct3
    do_op(0, 1, F_W,  32'h400, 32'h00000055, 0, "");
    do_op(1, 0, F_W,  32'h0,   0, 32'h00000055, "lw_wrap");
    do_op(0, 1, F_X,  32'h24,  32'hFFFFFFFF, 0, "");
    do_op(1, 0, F_W,  32'h24,  0, 32'h0, "illegal_store_dropped");

    // Read and write in the same cycle
    do_op(0, 1, F_W,  32'h20, 32'h00000001, 0, "");
    do_op(1, 1, F_W,  32'h20, 32'hA5A5A5A5, 32'h00000001, "rw_same_cycle_old");
    do_op(1, 0, F_W,  32'h20, 0, 32'hA5A5A5A5, "lw_after_rw");
    do_op(1, 0, F_X,  32'h20, 0, 32'h0, "illegal_load_zero");
    idle_op();

    // Restart the sweep mid-way; accesses during the sweep are ignored
    reset_pulse("sweep1");
    repeat (100) @(negedge clk);
    check("busy_at_cycle_100", {31'h0, Busy}, 32'h1);
    reset_pulse("sweep2");
    n_busy = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!Busy) break;
      n_busy++;
      #1;
      case (c)
        20: begin MemWrite = 1'b1; funct3 = F_W; Addr = 32'h8; WriteData = 32'h12345678; end
        21: Addr = 32'h22;
        22: begin MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h20; push("lw_while_busy", 32'h0); end
        23: MemRead = 1'b0;
        default: ;
      endcase
    end
    check("busy_len_restart", n_busy, 256);
    check("no_fault_while_busy", {31'h0, MisalignFault}, 32'h0);
    check("faultaddr_cleared", FaultAddr, 32'h0);
    do_op(1, 0, F_W, 32'h8,  0, 32'h0, "busy_store_dropped");
    do_op(1, 0, F_W, 32'h20, 0, 32'h0, "sweep_cleared_0x20");
    do_op(1, 0, F_W, 32'h0,  0, 32'h0, "sweep_cleared_0x00");
    idle_op();

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
